// File: rtl/kbd_pkg.sv
// Shared types for the keyboard event generator: reserved HID slot codes,
// the event word carried by the FIFO, and the scan FSM state encoding.
package kbd_pkg;

    localparam logic [7:0] KC_NONE     = 8'h00;
    localparam logic [7:0] KC_ROLLOVER = 8'h01;

    typedef struct packed {
        logic       make;
        logic [7:0] code;
    } kbd_event_t;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        BRK,
        MAK,
        COMMIT
    } kbd_state_t;

endpackage

// File: rtl/kbd_event_fifo.sv
// First-word-fall-through event FIFO. The head entry is presented while the
// FIFO is non-empty; a push on a full FIFO without a pop is dropped and flagged.
module kbd_event_fifo
    import kbd_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  kbd_event_t             push_data,
    input  logic                   pop,
    output kbd_event_t             head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   drop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    kbd_event_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    // A pop frees the slot this same cycle, so a full FIFO can still accept.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/kbd_event_gen.sv
// Debounces the 4-slot USB keycode word, diffs each stable snapshot against
// the last committed one and queues one make/break event per changed key.
//
//   state  | meaning
//   IDLE   | waiting for keycodes to differ from the committed snapshot
//   SETTLE | candidate must hold unchanged for STABLE_CYCLES cycles
//   BRK    | scan committed slots 0..3, queue releases
//   MAK    | scan candidate slots 0..3, queue presses
//   COMMIT | candidate becomes the committed snapshot
module kbd_event_gen
    import kbd_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int DEPTH         = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            keycodes,
    input  logic                   ev_rd,
    output logic                   ev_valid,
    output logic                   ev_make,
    output logic [7:0]             ev_code,
    output logic [$clog2(DEPTH):0] ev_count,
    output logic                   overflow,
    input  logic                   clr_ovf,
    output logic                   busy
);

    localparam int CW = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    kbd_state_t    state;
    logic [31:0]   prev;
    logic [31:0]   cand;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;

    logic [7:0] prev_s [4];
    logic [7:0] cand_s [4];
    logic [3:0] prev_in_cand;
    logic [3:0] prev_dup;
    logic [3:0] cand_in_prev;
    logic [3:0] cand_dup;
    logic       rollover;

    logic       push;
    kbd_event_t push_ev;
    kbd_event_t head;
    logic       fifo_empty;
    logic       drop;

    // Slot membership is positional-agnostic: a key moving between slots is not an event.
    always_comb begin
        rollover = 1'b0;
        for (int i = 0; i < 4; i++) begin
            prev_s[i] = prev[8*i +: 8];
            cand_s[i] = cand[8*i +: 8];
        end
        for (int i = 0; i < 4; i++) begin
            prev_in_cand[i] = 1'b0;
            prev_dup[i]     = 1'b0;
            cand_in_prev[i] = 1'b0;
            cand_dup[i]     = 1'b0;
            if (cand_s[i] == KC_ROLLOVER) begin
                rollover = 1'b1;
            end
            for (int j = 0; j < 4; j++) begin
                if (prev_s[i] == cand_s[j]) prev_in_cand[i] = 1'b1;
                if (cand_s[i] == prev_s[j]) cand_in_prev[i] = 1'b1;
                if (j < i && prev_s[i] == prev_s[j]) prev_dup[i] = 1'b1;
                if (j < i && cand_s[i] == cand_s[j]) cand_dup[i] = 1'b1;
            end
        end
    end

    always_comb begin
        push         = 1'b0;
        push_ev.make = (state == MAK);
        push_ev.code = (state == MAK) ? cand_s[idx] : prev_s[idx];
        if (state == BRK) begin
            push = (prev_s[idx] != KC_NONE) && !prev_in_cand[idx] && !prev_dup[idx];
        end else if (state == MAK) begin
            push = (cand_s[idx] != KC_NONE) && !cand_in_prev[idx] && !cand_dup[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            prev     <= '0;
            cand     <= '0;
            cnt      <= '0;
            idx      <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (keycodes != prev) begin
                        cand  <= keycodes;
                        cnt   <= '0;
                        state <= SETTLE;
                        busy  <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (keycodes != cand) begin
                        cand <= keycodes;
                        cnt  <= '0;
                    end else if (cnt == CNT_LAST) begin
                        if (rollover || cand == prev) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            idx   <= '0;
                            state <= BRK;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                BRK: begin
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        state <= MAK;
                    end
                end
                MAK: begin
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    prev  <= cand;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    kbd_event_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_ev),
        .pop       (ev_rd),
        .head      (head),
        .empty     (fifo_empty),
        .count     (ev_count),
        .drop      (drop)
    );

    assign ev_valid = !fifo_empty;
    assign ev_make  = head.make;
    assign ev_code  = head.code;

endmodule

// File: tb/tb_kbd_event_gen.sv
// Directed bench for kbd_event_gen: hand-computed event lists per keycode
// change, checked against the FIFO head as events are popped.
module tb_kbd_event_gen;

    localparam int S = 16;
    localparam int D = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] keycodes = 32'h0;
    logic        ev_rd = 1'b0;
    logic        clr_ovf = 1'b0;
    logic        ev_valid;
    logic        ev_make;
    logic [7:0]  ev_code;
    logic [4:0]  ev_count;
    logic        overflow;
    logic        busy;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [8:0]  exp_q [$];

    kbd_event_gen #(.STABLE_CYCLES(S), .DEPTH(D)) dut (
        .clk      (clk),
        .reset    (reset),
        .keycodes (keycodes),
        .ev_rd    (ev_rd),
        .ev_valid (ev_valid),
        .ev_make  (ev_make),
        .ev_code  (ev_code),
        .ev_count (ev_count),
        .overflow (overflow),
        .clr_ovf  (clr_ovf),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply(input logic [31:0] kc, input bit chk_idle);
        keycodes = kc;
        step(S + 14);
        if (chk_idle) chk("idle", {31'h0, busy}, 32'h0);
    endtask

    // Model of the FIFO capacity: events beyond DEPTH are dropped.
    task automatic model_push(input logic make, input logic [7:0] code);
        if (exp_q.size() < D) exp_q.push_back({make, code});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ":valid"}, {31'h0, ev_valid}, 32'h0);
        chk({tag, ":make"},  {31'h0, ev_make},  32'h0);
        chk({tag, ":code"},  {24'h0, ev_code},  32'h0);
        chk({tag, ":count"}, {27'h0, ev_count}, 32'h0);
        chk({tag, ":ovf"},   {31'h0, overflow}, 32'h0);
        chk({tag, ":busy"},  {31'h0, busy},     32'h0);
    endtask

    task automatic drain(input string tag);
        int n;
        logic [8:0] e;
        n = exp_q.size();
        chk({tag, ":count"}, {27'h0, ev_count}, n);
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            chk({tag, ":valid"}, {31'h0, ev_valid}, 32'h1);
            chk({tag, ":event"}, {23'h0, ev_make, ev_code}, {23'h0, e});
            ev_rd = 1'b1;
            step(1);
            ev_rd = 1'b0;
        end
        chk({tag, ":empty"}, {31'h0, ev_valid}, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int pp;
        logic do_rd;
        logic [8:0] e;

        step(2);
        chk_reset("rst");
        reset = 1'b0;
        step(1);

        // single key press
        keycodes = 32'h0000_0004;
        step(3);
        chk("t1_busy", {31'h0, busy}, 32'h1);
        step(S + 11);
        chk("t1_idle", {31'h0, busy}, 32'h0);
        model_push(1'b1, 8'h04);
        drain("t1");

        // break before make, key held across change produces nothing
        apply(32'h0000_0504, 1'b1);
        model_push(1'b1, 8'h05);
        drain("t2a");
        apply(32'h0000_0605, 1'b1);
        model_push(1'b0, 8'h04);
        model_push(1'b1, 8'h06);
        drain("t2b");

        // rollover snapshot is discarded; returning to committed value is silent
        apply(32'h0101_0101, 1'b0);
        drain("t3_rov");
        apply(32'h0000_0605, 1'b1);
        drain("t3_back");
        apply(32'h0000_0000, 1'b1);
        model_push(1'b0, 8'h05);
        model_push(1'b0, 8'h06);
        drain("t3_rel");
        keycodes = 32'h0000_0007;
        step(S - 1);
        apply(32'h0000_0000, 1'b1);
        drain("t3_glitch");

        // duplicates and permutations
        apply(32'h0000_0909, 1'b1);
        model_push(1'b1, 8'h09);
        drain("t4_dup");
        apply(32'h0000_0900, 1'b1);
        drain("t4_perm");

        // fill past capacity without reading
        apply(32'h0D0C_0B0A, 1'b1);
        model_push(1'b0, 8'h09);
        model_push(1'b1, 8'h0A);
        model_push(1'b1, 8'h0B);
        model_push(1'b1, 8'h0C);
        model_push(1'b1, 8'h0D);
        apply(32'h1110_0F0E, 1'b1);
        model_push(1'b0, 8'h0A);
        model_push(1'b0, 8'h0B);
        model_push(1'b0, 8'h0C);
        model_push(1'b0, 8'h0D);
        model_push(1'b1, 8'h0E);
        model_push(1'b1, 8'h0F);
        model_push(1'b1, 8'h10);
        model_push(1'b1, 8'h11);
        apply(32'h1200_0000, 1'b1);
        model_push(1'b0, 8'h0E);
        model_push(1'b0, 8'h0F);
        model_push(1'b0, 8'h10);
        model_push(1'b0, 8'h11);
        model_push(1'b1, 8'h12);
        chk("t5_full", {27'h0, ev_count}, 32'd16);
        chk("t5_ovf", {31'h0, overflow}, 32'h1);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        chk("t5_clr", {31'h0, overflow}, 32'h0);
        chk("t5_hold", {27'h0, ev_count}, 32'd16);

        // pop only while full until a push lands on the same cycle as a pop
        keycodes = 32'h0000_0015;
        exp_q.push_back({1'b0, 8'h12});
        exp_q.push_back({1'b1, 8'h15});
        pp = 0;
        for (int c = 0; c < S + 30 && pp == 0; c++) begin
            do_rd = (ev_count == 5'd16);
            if (do_rd) begin
                e = exp_q.pop_front();
                chk("t5_pophead", {23'h0, ev_make, ev_code}, {23'h0, e});
            end
            ev_rd = do_rd;
            step(1);
            ev_rd = 1'b0;
            if (do_rd && ev_count == 5'd16) pp = 1;
        end
        chk("t5_pushpop", pp, 32'h1);
        chk("t5_noovf", {31'h0, overflow}, 32'h0);
        step(10);
        drain("t5_drain");

        // reset in the middle of a scan
        keycodes = 32'h2C2B_2A29;
        step(S + 2);
        chk("t6_busy", {31'h0, busy}, 32'h1);
        reset = 1'b1;
        step(1);
        chk_reset("t6_rst");
        reset = 1'b0;
        step(S + 14);
        model_push(1'b1, 8'h29);
        model_push(1'b1, 8'h2A);
        model_push(1'b1, 8'h2B);
        model_push(1'b1, 8'h2C);
        drain("t6_after");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
